// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and a one-entry skid buffer.
// Optional M-extension decode enabled by defining DECODE_STAGE_MULDIV_EN.
module decode_stage #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic [3:0]      alu_op,
  output logic            mem_en,
  output logic [3:0]      mem_op,
  output logic [1:0]      opa_sel,
  output logic            opb_sel,
  output logic [3:0]      br_op,
  output logic [XLEN-1:0] imm,
  output logic            muldiv,
  output logic            illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [3:0]      alu_op;
    logic            mem_en;
    logic [3:0]      mem_op;
    logic [1:0]      opa_sel;
    logic            opb_sel;
    logic [3:0]      br_op;
    logic [XLEN-1:0] imm;
    logic            muldiv;
    logic            illegal;
  } bundle_t;

  logic            skid_valid;
  logic [31:0]     skid_ins;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     src_ins;
  logic [XLEN-1:0] src_pc;
  logic            load;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            bad;
  bundle_t         dec;
  bundle_t         bundle_q;
  logic [XLEN-1:0] pc_q;

  assign in_ready = !skid_valid;
  assign load     = !out_valid || out_ready;
  assign src_ins  = skid_valid ? skid_ins : in_ins;
  assign src_pc   = skid_valid ? skid_pc : in_pc;

  assign opcode = src_ins[6:0];
  assign f3     = src_ins[14:12];
  assign f7     = src_ins[31:25];

  // Raw 32-bit immediates; sign extension to XLEN happens on selection.
  assign imm_i = {{20{src_ins[31]}}, src_ins[31:20]};
  assign imm_s = {{20{src_ins[31]}}, src_ins[31:25], src_ins[11:7]};
  assign imm_b = {{19{src_ins[31]}}, src_ins[31], src_ins[7], src_ins[30:25], src_ins[11:8], 1'b0};
  assign imm_u = {src_ins[31:12], 12'h000};
  assign imm_j = {{11{src_ins[31]}}, src_ins[31], src_ins[19:12], src_ins[20], src_ins[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    dec.rs1 = src_ins[19:15];
    dec.rs2 = src_ins[24:20];
    dec.rd  = src_ins[11:7];
    case (opcode)
      OPC_LOAD: begin
        bad         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        dec.rd_we   = 1'b1;
        dec.mem_en  = 1'b1;
        dec.mem_op  = {1'b0, f3};
        dec.opb_sel = 1'b1;
        dec.imm     = XLEN'($signed(imm_i));
      end
      OPC_STORE: begin
        bad         = (f3 > 3'b010);
        dec.mem_en  = 1'b1;
        dec.mem_op  = {1'b1, f3};
        dec.opb_sel = 1'b1;
        dec.imm     = XLEN'($signed(imm_s));
      end
      OPC_BRANCH: begin
        bad       = (f3 == 3'b010) || (f3 == 3'b011);
        dec.br_op = {1'b1, f3};
        dec.imm   = XLEN'($signed(imm_b));
      end
      OPC_JALR: begin
        bad         = (f3 != 3'b000);
        dec.rd_we   = 1'b1;
        dec.br_op   = 4'b1011;
        dec.opb_sel = 1'b1;
        dec.imm     = XLEN'($signed(imm_i));
      end
      OPC_JAL: begin
        dec.rd_we   = 1'b1;
        dec.br_op   = 4'b1010;
        dec.opa_sel = 2'b01;
        dec.opb_sel = 1'b1;
        dec.imm     = XLEN'($signed(imm_j));
      end
      OPC_OPIMM: begin
        bad = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
              ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
        dec.rd_we   = 1'b1;
        dec.alu_op  = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
        dec.opb_sel = 1'b1;
        dec.imm     = XLEN'($signed(imm_i));
      end
      OPC_OP: begin
        dec.rd_we = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_op = {1'b0, f3};
        end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          dec.alu_op = {1'b1, f3};
        end
`ifdef DECODE_STAGE_MULDIV_EN
        else if (f7 == 7'b0000001) begin
          dec.alu_op = {1'b0, f3};
          dec.muldiv = 1'b1;
        end
`endif
        else begin
          bad = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.rd_we   = 1'b1;
        dec.opa_sel = 2'b10;
        dec.opb_sel = 1'b1;
        dec.imm     = XLEN'($signed(imm_u));
      end
      OPC_AUIPC: begin
        dec.rd_we   = 1'b1;
        dec.opa_sel = 2'b01;
        dec.opb_sel = 1'b1;
        dec.imm     = XLEN'($signed(imm_u));
      end
      OPC_FENCE, OPC_SYSTEM: begin
      end
      default: bad = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.rd_we = 1'b0;
    // Illegal encodings keep register fields but carry no side effects.
    if (bad) begin
      dec.rd_we   = 1'b0;
      dec.alu_op  = '0;
      dec.mem_en  = 1'b0;
      dec.mem_op  = '0;
      dec.opa_sel = '0;
      dec.opb_sel = 1'b0;
      dec.br_op   = '0;
      dec.imm     = '0;
      dec.muldiv  = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  // Output register plus skid entry; flush outranks any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      skid_ins   <= '0;
      skid_pc    <= '0;
      bundle_q   <= '0;
      pc_q       <= RESET_PC_OUT;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load) begin
      out_valid  <= skid_valid || in_valid;
      skid_valid <= 1'b0;
      if (skid_valid || in_valid) begin
        bundle_q <= dec;
        pc_q     <= src_pc;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_ins   <= in_ins;
      skid_pc    <= in_pc;
    end
  end

  assign out_pc  = pc_q;
  assign rs1     = bundle_q.rs1;
  assign rs2     = bundle_q.rs2;
  assign rd      = bundle_q.rd;
  assign rd_we   = bundle_q.rd_we;
  assign alu_op  = bundle_q.alu_op;
  assign mem_en  = bundle_q.mem_en;
  assign mem_op  = bundle_q.mem_op;
  assign opa_sel = bundle_q.opa_sel;
  assign opb_sel = bundle_q.opb_sel;
  assign br_op   = bundle_q.br_op;
  assign imm     = bundle_q.imm;
  assign muldiv  = bundle_q.muldiv;
  assign illegal = bundle_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I decode stage with valid/ready handshake on both sides and a one-entry skid buffer.
- Sits between fetch and execute. Converts the raw 32-bit instruction into ALU, memory, operand-select and writeback controls, plus a fully sign-extended immediate and an illegal-instruction flag.
- Parametrised successor of the combinational decoder:
  - full-width immediate instead of per-format 1-bit flags;
  - registered output with backpressure;
  - pipeline flush.

Parameters:
- XLEN, 32, datapath/PC width; legal values 32 or 64 (sets immediate sign-extension and PC width only; the RV64-only opcodes 0011011/0111011 are decoded as illegal).
- RESET_PC_OUT, 0, value driven on out_pc while reset is asserted.

Ports:
- clk input 1: clock, rising edge.
- rst input 1: reset, asynchronous, active-high.
- flush input 1: synchronous kill of all held instructions.
- in_valid input 1: fetch offers an instruction.
- in_ready output 1: stage can accept; equals !skid_valid.
- in_ins input 32: raw instruction.
- in_pc input XLEN: PC of in_ins.
- out_valid output 1: decoded bundle valid.
- out_ready input 1: execute accepts the bundle.
- out_pc output XLEN: PC of the decoded instruction.
- rs1 output 5: ins[19:15].
- rs2 output 5: ins[24:20].
- rd output 5: ins[11:7].
- rd_we output 1: register writeback enable.
- alu_op output 4: ALU function.
- mem_en output 1: load or store.
- mem_op output 4: {store, funct3}.
- opa_sel output 2: 00 rs1, 01 pc, 10 zero.
- opb_sel output 1: 0 rs2, 1 imm.
- br_op output 4: {is_branch_or_jump, type[2:0]}.
- imm output XLEN: sign-extended immediate.
- muldiv output 1: M-extension operation.
- illegal output 1: undecodable instruction.

Behaviour:
- Reset (asynchronous): out_valid=0, skid_valid=0, all bundle outputs 0, out_pc=RESET_PC_OUT. in_ready=1 during and after reset.
- Latency: 1 cycle from in_valid&&in_ready to out_valid when the output register is free.
- Output register loads when !out_valid || out_ready. Load source is the skid entry if skid_valid, else the input.
- Skid capture: out_valid && !out_ready && in_valid && in_ready → raw ins/pc go into the skid entry, skid_valid=1, and in_ready drops the next cycle.
- Skid drain: skid drains on the next out_ready; skid_valid clears on that edge. An input accepted on the same edge is impossible, since in_ready=0 while the skid is full.
- Bundle stability: bundle outputs must not change while out_valid && !out_ready.
- Flush: has priority over everything. On the next edge out_valid=0 and skid_valid=0; in_valid in the flush cycle is dropped (not accepted).
- Immediate formats, sign-extended from ins[31]:
  - I: loads, OP-IMM, JALR.
  - S: stores.
  - B: branches, bit0=0.
  - U: LUI/AUIPC, low 12 bits zero.
  - J: JAL, bit0=0.
  - imm=0 for OP.
- alu_op:
  - OP: {funct7[5], funct3}.
  - OP-IMM: {funct3==101 ? funct7[5] : 0, funct3}.
  - LUI, AUIPC, LOAD, STORE, JAL, JALR: 0000 (ADD).
  - BRANCH: 0000 (comparison is done by the branch unit).
- Operand selects:
  - opa_sel: AUIPC and JAL → 01; LUI → 10; otherwise 00.
  - opb_sel=1 for everything except OP and BRANCH.
- rd_we=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR. rd_we is forced 0 when rd==0.
- br_op: BRANCH → {1, funct3}; JAL → 1010; JALR → 1011; else 0000.
- Illegal conditions:
  - ins[1:0]!=11;
  - unknown opcode;
  - LOAD funct3 in {011,110,111};
  - STORE funct3>010;
  - BRANCH funct3 in {010,011};
  - JALR funct3!=000;
  - OP funct7 not 0000000, or 0100000 with funct3 outside {000,101};
  - OP-IMM shift with a bad funct7.
- Illegal response: illegal=1, rd_we=0, mem_en=0, br_op=0. out_valid still asserts and out_pc is kept.
- FENCE (0001111) and SYSTEM (1110011) are legal; both produce an all-zero bundle (NOP).

Optional Feature:
- Macro DECODE_STAGE_MULDIV_EN.
- Defined: OP with funct7=0000001 is legal, with muldiv=1, alu_op={0,funct3}, rd_we per the rd rule.
- Undefined: that encoding is illegal and muldiv is tied to 0.

Test Plan:
- Reset mid-stream with out_valid=1 → out_valid=0 and in_ready=1 immediately (asynchronous); out_pc=RESET_PC_OUT.
- in_ins=0xFFF00093 (addi x1,x0,-1), pc=0x100 → next cycle:
  - imm=0xFFFFFFFF, rd=1, rd_we=1, alu_op=0000, opb_sel=1;
  - out_pc=0x100.
- out_ready=0, then feed 0x40208033 (sub) and 0x00112223 (sw):
  - first held stable, second in skid, in_ready=0;
  - out_ready=1 → sw appears with mem_op=1010, imm=4, rd_we=0.
- Flush asserted while skid full and in_valid=1 → out_valid=0, in_ready=1 next cycle, no instruction emitted.
- 0x02208033 (mul) → illegal=0, muldiv=1 with the macro; illegal=1, rd_we=0 without it.
- 0xFE000EE3 (beq, offset -4) → imm=0xFFFFFFFC, br_op=1000, opb_sel=0, rd_we=0.
